id_hazard_ctrl: RTL and testbench
=================================

Name: id_hazard_ctrl

Overview:
- Pipeline hazard controller sitting directly upstream of the ID/EX register.
- Decides each cycle whether the PC and IF/ID hold, whether IF/ID is flushed, and whether ID/EX receives a bubble (all control fields zeroed) instead of the decoded ID instruction.
- Handles three hazards: load-use, multi-cycle multiply occupancy and taken-branch redirect.
- Holds a small FSM plus a down-counter for the multiply wait.

Parameters:
- MUL_LATENCY, 3: EX cycles a MUL/MADD/MSUB occupies; 1 means no wait.
- CNT_W, 4: multiply counter width; MUL_LATENCY must be < 2**CNT_W.

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Reset  in  1  synchronous, active-high.
- ID_Valid  in  1  ID holds a real instruction, not a bubble.
- ID_Rs  in  5  source register field [25:21].
- ID_Rt  in  5  source register field [20:16].
- ID_UsesRs  in  1  instruction reads Rs.
- ID_UsesRt  in  1  instruction reads Rt.
- ID_IsMul  in  1  instruction is a multi-cycle multiply.
- EX_MemRead  in  1  instruction in EX is a load.
- EX_WriteReg  in  5  destination register of the instruction in EX, after RegDst.
- EX_BranchTaken  in  1  branch/jump in EX resolved taken.
- PCWrite  out  1  PC update enable.
- IFID_Write  out  1  IF/ID load enable.
- IFID_Flush  out  1  IF/ID cleared to NOP on the next edge.
- IDEX_Bubble  out  1  ID/EX control inputs forced to 0 on the next edge.
- MulBusy  out  1  FSM is in MUL_WAIT.

Behaviour:
- Clocking and reset: one clock Clk; Reset is synchronous, active-high.
- Registered state: state (RUN, MUL_WAIT) and cnt[CNT_W-1:0]. On Reset: state=RUN, cnt=0.
- Outputs are combinational from state, cnt and the inputs; there is no output register.
- While Reset=1: PCWrite=0, IFID_Write=0, IFID_Flush=1, IDEX_Bubble=1, MulBusy=0.
- load_use = ID_Valid & EX_MemRead & (EX_WriteReg!=0) & ((ID_UsesRs & ID_Rs==EX_WriteReg) | (ID_UsesRt & ID_Rt==EX_WriteReg)).
- Output priority, highest first:
  1. EX_BranchTaken: PCWrite=1, IFID_Write=1, IFID_Flush=1, IDEX_Bubble=1. The ID instruction is killed, so no MUL_WAIT entry even if ID_IsMul.
  2. state==MUL_WAIT: PCWrite=0, IFID_Write=0, IDEX_Bubble=1, IFID_Flush=0.
  3. load_use: PCWrite=0, IFID_Write=0, IDEX_Bubble=1, IFID_Flush=0. Exactly one stall cycle; on the next cycle the load is in MEM and is resolved by forwarding.
  4. Otherwise: PCWrite=1, IFID_Write=1, IFID_Flush=0, IDEX_Bubble=0.
- Multiply issue: in RUN with ID_Valid & ID_IsMul & !EX_BranchTaken & !load_use & MUL_LATENCY>1, the multiply passes into ID/EX this cycle. The next state is MUL_WAIT with cnt=MUL_LATENCY-2.
- In MUL_WAIT:
  - If cnt==0, go to RUN.
  - Otherwise decrement cnt.
  - The total number of stall cycles after issue is MUL_LATENCY-1.
- A multiply held back by load_use issues on the first cycle load_use clears.
- With MUL_LATENCY==1 the FSM never leaves RUN.
- A multiply whose sources match a pending load: the load-use stall happens first, then the multiply issues.
- Reset asserted during MUL_WAIT: the next state is RUN with cnt=0; there is no residual stall.
- EX_WriteReg==0 never causes a stall.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined: adds outputs StallCycles[31:0] and FlushCount[31:0], both 0 on Reset and saturating at 0xFFFFFFFF.
  - StallCycles increments on every cycle with PCWrite=0 and Reset=0.
  - FlushCount increments on every cycle with IFID_Flush=1 and Reset=0.
- When undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package hazard_pkg holds: the state enum (RUN, MUL_WAIT), REG_ZERO=5'd0, and the default MUL_LATENCY constant shared with the EX multiplier.
- One sub-module, mul_wait_counter: holds the load value, the decrement and the zero flag, and is instantiated once.

Test Plan:
- Reset held 2 cycles with ID_IsMul=1 → outputs PCWrite=0, IFID_Flush=1, IDEX_Bubble=1, MulBusy=0. After release, RUN with PCWrite=1.
- EX_MemRead=1, EX_WriteReg=8, ID_Rt=8, ID_UsesRt=1 → exactly 1 cycle of PCWrite=0, IFID_Write=0, IDEX_Bubble=1. Repeat with EX_WriteReg=0 → no stall.
- ID_IsMul=1, MUL_LATENCY=3 → issue cycle shows no stall, then 2 cycles with MulBusy=1 and IDEX_Bubble=1, then RUN. With MUL_LATENCY=1 → never busy.
- EX_BranchTaken=1 in the same cycle as ID_IsMul=1 and load_use → IFID_Flush=1, PCWrite=1, IDEX_Bubble=1, and the FSM stays in RUN.
- Reset pulsed during the 2nd MUL_WAIT cycle → after release MulBusy=0 and PCWrite=1.
- With HAZARD_STATS_EN: 1 load-use stall, 2 mul stalls and 1 flush → StallCycles=3, FlushCount=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared hazard-control types and constants, also used by the EX multiplier.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int MUL_LATENCY_DEFAULT = 3;

endpackage

// File: rtl/mul_wait_counter.sv
// Down-counter that tracks the remaining multiply occupancy.
// The zero flag is the terminal count that ends MUL_WAIT.
module mul_wait_counter #(
  parameter int CNT_W    = 4,
  parameter int LOAD_VAL = 1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic load,
  input  logic dec,
  output logic cnt_zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(LOAD_VAL);
    end else if (dec) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/id_hazard_ctrl.sv
// Hazard controller ahead of ID/EX: load-use stall, multiply occupancy, branch flush.
// Optional stall/flush counters are enabled with HAZARD_STATS_EN.
//
// state    | meaning
// RUN      | normal issue; load-use and branch handled combinationally
// MUL_WAIT | multiply occupying EX; ID held and bubbles sent until count expires
module id_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_LATENCY = MUL_LATENCY_DEFAULT,
  parameter int CNT_W       = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ID_Valid,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_UsesRs,
  input  logic       ID_UsesRt,
  input  logic       ID_IsMul,
  input  logic       EX_MemRead,
  input  logic [4:0] EX_WriteReg,
  input  logic       EX_BranchTaken,
  output logic       PCWrite,
  output logic       IFID_Write,
  output logic       IFID_Flush,
  output logic       IDEX_Bubble,
  output logic       MulBusy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount
`endif
);

  localparam logic MUL_MULTI = (MUL_LATENCY > 1);
  localparam int   LOAD_VAL  = (MUL_LATENCY > 1) ? (MUL_LATENCY - 2) : 0;

  hz_state_t state, next_state;
  logic load_use, mul_issue, cnt_load, cnt_dec, cnt_zero;

  assign load_use = ID_Valid & EX_MemRead & (EX_WriteReg != REG_ZERO) &
                    ((ID_UsesRs & (ID_Rs == EX_WriteReg)) |
                     (ID_UsesRt & (ID_Rt == EX_WriteReg)));

  // A multiply killed by a branch or held by load-use must not start the wait.
  assign mul_issue = MUL_MULTI & ID_Valid & ID_IsMul & ~EX_BranchTaken & ~load_use;

  mul_wait_counter #(
    .CNT_W   (CNT_W),
    .LOAD_VAL(LOAD_VAL)
  ) u_mul_cnt (
    .Clk     (Clk),
    .Reset   (Reset),
    .load    (cnt_load),
    .dec     (cnt_dec),
    .cnt_zero(cnt_zero)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state <= RUN;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Bubble = 1'b0;
    MulBusy     = (state == MUL_WAIT);

    case (state)
      RUN: begin
        if (mul_issue) begin
          next_state = MUL_WAIT;
          cnt_load   = 1'b1;
        end
      end
      MUL_WAIT: begin
        if (cnt_zero) next_state = RUN;
        else          cnt_dec    = 1'b1;
      end
      default: next_state = RUN;
    endcase

    if (EX_BranchTaken) begin
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
    end else if (state == MUL_WAIT || load_use) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
    end

    if (Reset) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
      MulBusy     = 1'b0;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      if (!PCWrite && StallCycles != 32'hFFFF_FFFF) StallCycles <= StallCycles + 1'b1;
      if (IFID_Flush && FlushCount != 32'hFFFF_FFFF) FlushCount <= FlushCount + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench for id_hazard_ctrl: latency-3 and latency-1 instances
// against a stall-budget model, plus hand-computed literal expectations.
module tb_id_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       ID_Valid, ID_UsesRs, ID_UsesRt, ID_IsMul;
  logic [4:0] ID_Rs, ID_Rt, EX_WriteReg;
  logic       EX_MemRead, EX_BranchTaken;

  logic pcw3, ifw3, flush3, bub3, busy3;
  logic pcw1, ifw1, flush1, bub1, busy1;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall3, flcnt3, stall1, flcnt1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  id_hazard_ctrl #(.MUL_LATENCY(3), .CNT_W(4)) dut3 (
    .Clk(Clk), .Reset(Reset), .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_IsMul(ID_IsMul),
    .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg), .EX_BranchTaken(EX_BranchTaken),
    .PCWrite(pcw3), .IFID_Write(ifw3), .IFID_Flush(flush3), .IDEX_Bubble(bub3), .MulBusy(busy3)
`ifdef HAZARD_STATS_EN
    , .StallCycles(stall3), .FlushCount(flcnt3)
`endif
  );

  id_hazard_ctrl #(.MUL_LATENCY(1), .CNT_W(4)) dut1 (
    .Clk(Clk), .Reset(Reset), .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_IsMul(ID_IsMul),
    .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg), .EX_BranchTaken(EX_BranchTaken),
    .PCWrite(pcw1), .IFID_Write(ifw1), .IFID_Flush(flush1), .IDEX_Bubble(bub1), .MulBusy(busy1)
`ifdef HAZARD_STATS_EN
    , .StallCycles(stall1), .FlushCount(flcnt1)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the multiply occupancy is just a number of stall cycles still owed.
  int left3 = 0, left1 = 0;
  int m_stall3 = 0, m_flush3 = 0, m_stall1 = 0, m_flush1 = 0;
  bit started = 0;

  function automatic logic model_lu();
    return ID_Valid && EX_MemRead && EX_WriteReg != 0 &&
           ((ID_UsesRs && ID_Rs == EX_WriteReg) || (ID_UsesRt && ID_Rt == EX_WriteReg));
  endfunction

  // {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, MulBusy}
  function automatic logic [4:0] model_out(input int left);
    if (Reset)          return 5'b00110;
    if (EX_BranchTaken) return {4'b1111, left > 0};
    if (left > 0)       return 5'b00011;
    if (model_lu())     return 5'b00010;
    return 5'b11000;
  endfunction

  function automatic int next_left(input int left, input int lat);
    if (Reset)    return 0;
    if (left > 0) return left - 1;
    if (ID_Valid && ID_IsMul && !EX_BranchTaken && !model_lu() && lat > 1) return lat - 1;
    return 0;
  endfunction

  always @(posedge Clk) begin
    logic [4:0] e3, e1;
    e3 = model_out(left3);
    e1 = model_out(left1);
    if (Reset) begin
      m_stall3 = 0; m_flush3 = 0; m_stall1 = 0; m_flush1 = 0;
    end else begin
      if (!e3[4]) m_stall3++;
      if (e3[2])  m_flush3++;
      if (!e1[4]) m_stall1++;
      if (e1[2])  m_flush1++;
    end
    left3 = next_left(left3, 3);
    left1 = next_left(left1, 1);
    started = 1;
  end

  always @(negedge Clk) begin
    if (started) begin
      chk("model_lat3", {pcw3, ifw3, flush3, bub3, busy3}, 32'(model_out(left3)));
      chk("model_lat1", {pcw1, ifw1, flush1, bub1, busy1}, 32'(model_out(left1)));
`ifdef HAZARD_STATS_EN
      chk("stall_lat3", stall3, m_stall3);
      chk("flush_lat3", flcnt3, m_flush3);
      chk("stall_lat1", stall1, m_stall1);
      chk("flush_lat1", flcnt1, m_flush1);
`endif
    end
  end

  task automatic idle();
    ID_Valid = 1; ID_Rs = 5'd1; ID_Rt = 5'd2; ID_UsesRs = 1; ID_UsesRt = 1;
    ID_IsMul = 0; EX_MemRead = 0; EX_WriteReg = 5'd20; EX_BranchTaken = 0;
  endtask

  // Literal check of the latency-3 instance: e = {PCWrite, IFID_Flush, IDEX_Bubble, MulBusy}
  task automatic cyc_lit(input string name, input logic [3:0] e);
    @(negedge Clk);
    chk(name, {pcw3, flush3, bub3, busy3}, 32'(e));
    @(posedge Clk); #1;
  endtask

  task automatic cyc();
    @(posedge Clk); #1;
  endtask

  initial begin
    idle();
    Reset = 1; ID_IsMul = 1;
    cyc_lit("reset_c0", 4'b0110);
    cyc_lit("reset_c1", 4'b0110);
    Reset = 0; idle();
    cyc_lit("run_after_reset", 4'b1000);

    // load-use on Rt
    EX_MemRead = 1; EX_WriteReg = 5'd8; ID_Rt = 5'd8;
    @(negedge Clk); chk("lu_ifid_write", ifw3, 1'b0); @(posedge Clk); #1;
    idle();
    cyc_lit("lu_one_cycle_only", 4'b1000);
    // destination r0 never stalls
    EX_MemRead = 1; EX_WriteReg = 5'd0; ID_Rt = 5'd0; ID_Rs = 5'd0;
    cyc_lit("lu_r0_no_stall", 4'b1000);
    // match on a source that is not read
    idle(); EX_MemRead = 1; EX_WriteReg = 5'd3; ID_Rs = 5'd3; ID_UsesRs = 0;
    cyc_lit("lu_unused_src", 4'b1000);
    // bubble in ID
    idle(); EX_MemRead = 1; EX_WriteReg = 5'd1; ID_Valid = 0;
    cyc_lit("lu_invalid_id", 4'b1000);
    // load-use on Rs
    idle(); EX_MemRead = 1; EX_WriteReg = 5'd1;
    cyc_lit("lu_rs", 4'b0010);

    // multiply: issue, two busy cycles, back to RUN
    idle(); ID_IsMul = 1;
    @(negedge Clk);
    chk("mul_issue", {pcw3, bub3, busy3}, 3'b100);
    @(posedge Clk); #1;
    idle();
    @(negedge Clk); chk("lat1_never_busy", {busy1, pcw1}, 2'b01); @(posedge Clk); #1;
    cyc_lit("mul_wait_c1", 4'b0011);
    cyc_lit("mul_wait_back", 4'b1000);

    // branch with mul and load-use in ID: flush, no MUL_WAIT
    EX_BranchTaken = 1; ID_IsMul = 1; EX_MemRead = 1; EX_WriteReg = 5'd5; ID_Rs = 5'd5;
    cyc_lit("branch_priority", 4'b1110);
    idle();
    cyc_lit("branch_no_mulwait", 4'b1000);

    // multiply behind a load: stall first, then issue, then wait
    ID_IsMul = 1; EX_MemRead = 1; EX_WriteReg = 5'd9; ID_Rt = 5'd9;
    cyc_lit("mul_lu_stall", 4'b0010);
    EX_MemRead = 0;
    cyc_lit("mul_lu_issue", 4'b1000);
    idle();
    cyc_lit("mul_lu_wait0", 4'b0011);
    cyc_lit("mul_lu_wait1", 4'b0011);
    cyc_lit("mul_lu_done", 4'b1000);

    // reset during the second MUL_WAIT cycle
    ID_IsMul = 1;
    cyc();
    idle();
    cyc_lit("rst_mul_wait0", 4'b0011);
    Reset = 1;
    cyc_lit("rst_mul_in_reset", 4'b0110);
    Reset = 0;
    cyc_lit("rst_mul_released", 4'b1000);

    // statistics scenario: 1 load-use stall, 2 mul stalls, 1 flush
    Reset = 1; cyc();
    Reset = 0; EX_MemRead = 1; EX_WriteReg = 5'd2;
    cyc();
    idle(); ID_IsMul = 1;
    cyc();
    idle();
    cyc(); cyc();
    EX_BranchTaken = 1;
    cyc();
    idle();
    @(negedge Clk);
`ifdef HAZARD_STATS_EN
    chk("stats_stall", stall3, 32'd3);
    chk("stats_flush", flcnt3, 32'd1);
`endif
    chk("stats_end_run", {pcw3, busy3}, 2'b10);
    @(posedge Clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
